serial_digit_subtractor: RTL

Multi-cycle, parametrised successor to the single-bit full subtractor. Computes D = A − B − Bin on WIDTH-bit operands, DIGIT bits per clock. A registered borrow chains between digits, so area scales with DIGIT rather than WIDTH. Uses a start/busy/done handshake. Also reports unsigned borrow-out, signed overflow and zero, so the block can serve as the datapath subtract/compare unit.

---
 rtl/serial_digit_subtractor_if.sv | 28 ++
 rtl/serial_digit_subtractor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_digit_subtractor_if.sv
// Handshake and operand/result bundle for serial_digit_subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout, ovf, zero
//   slave  : the subtractor itself
// WIDTH must match the WIDTH of the attached subtractor.
interface serial_digit_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_digit_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), DIGIT bits per
// clock, borrow carried between digits in a register. NDIG = WIDTH/DIGIT
// cycles per operation, start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   sif        : slave side of serial_digit_subtractor_if
//                start/a/b/bin in; busy, done (1-cycle pulse), diff,
//                bout (unsigned borrow-out), ovf (signed overflow), zero out
// Result outputs only change on the completing edge and hold otherwise.
module serial_digit_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_digit_subtractor_if.slave sif
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] a_dig, b_dig, dig;
    logic [DIGIT:0]   sub;
    logic             last;

    // Digit slice for the current step; the extra top bit of the
    // DIGIT+1-bit difference is the outgoing borrow.
    always_comb begin
        a_dig = a_q[int'(cnt_q)*DIGIT +: DIGIT];
        b_dig = b_q[int'(cnt_q)*DIGIT +: DIGIT];
        sub   = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
        dig   = sub[DIGIT-1:0];
        last  = (cnt_q == CW'(NDIG - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    a_d     = sif.a;
                    b_d     = sif.b;
                    brw_d   = sif.bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(cnt_q)*DIGIT +: DIGIT] = dig;
                brw_d = sub[DIGIT];
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    // Publish all flags from the completed word at once so
                    // they are mutually consistent with diff.
                    diff_d  = res_d;
                    bout_d  = sub[DIGIT];
                    zero_d  = (res_d == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sif.busy = (state_q == RUN);
    assign sif.done = done_q;
    assign sif.diff = diff_q;
    assign sif.bout = bout_q;
    assign sif.ovf  = ovf_q;
    assign sif.zero = zero_q;
endmodule
